// File: rtl/time_fmt_pkg.sv
// time_fmt_pkg: shared definitions for the BCD time formatting path.
//   - Field-slice localparams for the 20-bit BCD time word (HT_MSB..SU_LSB).
//   - bcd_time_t: packed struct of the six BCD digits, same layout as the word.
//   - BLANK_DIGIT: hour-tens code the display decoder renders as blank.
//   - is_legal_time(): legality check of a 24 h BCD time word.
package time_fmt_pkg;

    localparam int unsigned HT_MSB = 19;
    localparam int unsigned HT_LSB = 18;
    localparam int unsigned HU_MSB = 17;
    localparam int unsigned HU_LSB = 14;
    localparam int unsigned MT_MSB = 13;
    localparam int unsigned MT_LSB = 11;
    localparam int unsigned MU_MSB = 10;
    localparam int unsigned MU_LSB = 7;
    localparam int unsigned ST_MSB = 6;
    localparam int unsigned ST_LSB = 4;
    localparam int unsigned SU_MSB = 3;
    localparam int unsigned SU_LSB = 0;

    localparam logic [1:0] BLANK_DIGIT = 2'b11;

    typedef struct packed {
        logic [1:0] ht;
        logic [3:0] hu;
        logic [2:0] mt;
        logic [3:0] mu;
        logic [2:0] st;
        logic [3:0] su;
    } bcd_time_t;

    function automatic logic is_legal_time(input logic [19:0] w);
        logic [1:0] ht;
        logic [3:0] hu;
        logic [2:0] mt;
        logic [3:0] mu;
        logic [2:0] st;
        logic [3:0] su;
        ht = w[HT_MSB:HT_LSB];
        hu = w[HU_MSB:HU_LSB];
        mt = w[MT_MSB:MT_LSB];
        mu = w[MU_MSB:MU_LSB];
        st = w[ST_MSB:ST_LSB];
        su = w[SU_MSB:SU_LSB];
        return !((ht > 2'd2) || (hu > 4'd9) || ((ht == 2'd2) && (hu > 4'd3)) ||
                 (mt > 3'd5) || (mu > 4'd9) || (st > 3'd5) || (su > 4'd9));
    endfunction

endpackage

// File: rtl/time_fmt_pipe_hour_24to12.sv
// hour_24to12: combinational 24 h -> 12 h hour converter.
//   hour_tens, hour_units   : legal BCD hour 00..23
//   hour12_tens, hour12_units: BCD hour 01..12
//   pm                      : 1 for hours 12..23
// Output is meaningless for illegal input hours; callers gate on legality.
module hour_24to12 (
    input  logic [1:0] hour_tens,
    input  logic [3:0] hour_units,
    output logic [1:0] hour12_tens,
    output logic [3:0] hour12_units,
    output logic       pm
);

    logic [4:0] hour;
    logic [4:0] hour12;

    always_comb begin
        hour = 5'(hour_tens) * 5'd10 + 5'(hour_units);
        pm   = (hour >= 5'd12);
        if (hour == 5'd0) begin
            hour12 = 5'd12;
        end else if (hour > 5'd12) begin
            hour12 = hour - 5'd12;
        end else begin
            hour12 = hour;
        end
        if (hour12 >= 5'd10) begin
            hour12_tens  = 2'd1;
            hour12_units = 4'(hour12 - 5'd10);
        end else begin
            hour12_tens  = 2'd0;
            hour12_units = hour12[3:0];
        end
    end

endmodule

// File: rtl/time_fmt_pipe.sv
// time_fmt_pipe: two-stage, multi-channel 12/24 h BCD time formatter.
// Optional feature macro: LEAD_ZERO_BLANK_EN (blank a leading-zero hour tens digit).
// Ports:
//   clk, reset (sync, active-low)
//   mode12_24[N_CH] : per-channel mode, 1 = 12 h AM/PM, 0 = 24 h
//   in_valid/in_ready, in_ch, in_time   : input word handshake
//   out_valid/out_ready, out_ch, out_time, out_pm, out_err : output handshake
//   err_cnt         : saturating count of illegal words entering stage 2
// Stage 1 captures the word, its channel mode and legality; stage 2 holds the
// formatted result and acts as the output register.
module time_fmt_pipe
    import time_fmt_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned ERR_CNT_W = 8,
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      mode12_24,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH_W-1:0]      in_ch,
    input  logic [19:0]          in_time,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [19:0]          out_time,
    output logic                 out_pm,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LeadBlank = 1'b1;
`else
    localparam bit LeadBlank = 1'b0;
`endif

    localparam int unsigned NIdx = 1 << CH_W;

    logic                 s1_full_q;
    logic [CH_W-1:0]      s1_ch_q;
    bcd_time_t            s1_time_q;
    logic                 s1_mode_q;
    logic                 s1_legal_q;

    logic                 out_valid_q;
    logic [CH_W-1:0]      out_ch_q;
    logic [19:0]          out_time_q;
    logic                 out_pm_q;
    logic                 out_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic                 s2_adv;
    logic                 s1_adv;
    logic                 s1_load;

    // Mode and channel-valid tables padded to the full index range so an
    // out-of-range tag reads mode 0 and is flagged illegal.
    logic [NIdx-1:0]      mode_ext;
    logic [NIdx-1:0]      ch_ok;
    logic                 in_mode;
    logic                 in_legal;

    logic [1:0]           h12_tens;
    logic [3:0]           h12_units;
    logic                 h12_pm;
    bcd_time_t            fmt_time;
    logic                 fmt_pm;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = s1_full_q && s2_adv;
    assign in_ready = reset && !(s1_full_q && out_valid_q && !out_ready);
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        mode_ext = '0;
        ch_ok    = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            mode_ext[i] = mode12_24[i];
            ch_ok[i]    = 1'b1;
        end
    end

    assign in_mode  = mode_ext[in_ch];
    assign in_legal = ch_ok[in_ch] && is_legal_time(in_time);

    hour_24to12 u_hour_24to12 (
        .hour_tens    (s1_time_q.ht),
        .hour_units   (s1_time_q.hu),
        .hour12_tens  (h12_tens),
        .hour12_units (h12_units),
        .pm           (h12_pm)
    );

    // Illegal words pass through untouched with pm forced low.
    always_comb begin
        fmt_time = s1_time_q;
        fmt_pm   = 1'b0;
        if (s1_legal_q) begin
            if (s1_mode_q) begin
                fmt_time.ht = h12_tens;
                fmt_time.hu = h12_units;
                fmt_pm      = h12_pm;
            end
            if (LeadBlank && (fmt_time.ht == 2'd0)) begin
                fmt_time.ht = BLANK_DIGIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_full_q  <= 1'b0;
            s1_ch_q    <= '0;
            s1_time_q  <= '0;
            s1_mode_q  <= 1'b0;
            s1_legal_q <= 1'b0;
        end else if (s1_load) begin
            s1_full_q  <= 1'b1;
            s1_ch_q    <= in_ch;
            s1_time_q  <= bcd_time_t'(in_time);
            s1_mode_q  <= in_mode;
            s1_legal_q <= in_legal;
        end else if (s1_adv) begin
            s1_full_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_time_q  <= '0;
            out_pm_q    <= 1'b0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (s1_adv) begin
                out_valid_q <= 1'b1;
                out_ch_q    <= s1_ch_q;
                out_time_q  <= fmt_time;
                out_pm_q    <= fmt_pm;
                out_err_q   <= !s1_legal_q;
                if (!s1_legal_q && (err_cnt_q != '1)) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_time  = out_time_q;
    assign out_pm    = out_pm_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_time_fmt_pipe.sv
// Directed testbench for time_fmt_pipe (N_CH = 2, ERR_CNT_W = 8).
module tb_time_fmt_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode12_24;
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  in_ch;
    logic [19:0] in_time;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_ch;
    logic [19:0] out_time;
    logic        out_pm;
    logic        out_err;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Stream tables: word, channel, mode vector, expected time/pm/err.
    logic [19:0] sw [8];
    logic [0:0]  sc [8];
    logic [1:0]  sm [8];
    logic [19:0] se [8];
    logic        sp [8];
    logic        sx [8];

    time_fmt_pipe #(
        .N_CH      (2),
        .ERR_CNT_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode12_24 (mode12_24),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_time   (in_time),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_time  (out_time),
        .out_pm    (out_pm),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] raw(input int ht, input int hu, input int mt, input int mu,
                                        input int st, input int su);
        return {2'(ht), 4'(hu), 3'(mt), 4'(mu), 3'(st), 4'(su)};
    endfunction

    function automatic logic [19:0] tm(input int h, input int m, input int s);
        return raw(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
    endfunction

    // Leading-zero hour blanking applies to legal words only.
    function automatic logic [19:0] exp_fix(input logic [19:0] t, input logic err);
        logic [19:0] r;
        r = t;
`ifdef LEAD_ZERO_BLANK_EN
        if (!err && (r[19:18] == 2'd0)) r[19:18] = 2'b11;
`endif
        return r;
    endfunction

    task automatic set_w(input int k, input logic [19:0] w, input logic [0:0] ch,
                         input logic [1:0] m, input logic [19:0] e, input logic p,
                         input logic x);
        sw[k] = w; sc[k] = ch; sm[k] = m; se[k] = e; sp[k] = p; sx[k] = x;
    endtask

    // Back-to-back words with out_ready = 1; word k must appear exactly two
    // cycles after it is driven.
    task automatic stream(input string tag, input int n);
        for (int c = 0; c < n + 2; c++) begin
            @(posedge clk); #1;
            if (c < n) begin
                in_valid  = 1'b1;
                in_time   = sw[c];
                in_ch     = sc[c];
                mode12_24 = sm[c];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < n) check({tag, "_in_ready"}, in_ready, 1);
            if (c >= 2) begin
                check({tag, "_valid"}, out_valid, 1);
                check({tag, "_time"}, out_time, exp_fix(se[c-2], sx[c-2]));
                check({tag, "_pm"}, out_pm, sp[c-2]);
                check({tag, "_err"}, out_err, sx[c-2]);
                check({tag, "_ch"}, out_ch, sc[c-2]);
            end else begin
                check({tag, "_idle"}, out_valid, 0);
            end
        end
    endtask

    task automatic flood(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_ch    = 1'b0;
            in_time  = tm(24, 0, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int sent;
        int rcv;

        reset     = 1'b0;
        mode12_24 = 2'b00;
        in_valid  = 1'b0;
        in_ch     = 1'b0;
        in_time   = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_time", out_time, 0);
        check("rst_out_pm", out_pm, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);

        // 12 h conversion on channel 0
        set_w(0, tm(23, 59, 59), 1'b0, 2'b01, tm(11, 59, 59), 1'b1, 1'b0);
        set_w(1, tm(0, 0, 0),    1'b0, 2'b01, tm(12, 0, 0),   1'b0, 1'b0);
        set_w(2, tm(12, 30, 0),  1'b0, 2'b01, tm(12, 30, 0),  1'b1, 1'b0);
        set_w(3, tm(13, 5, 7),   1'b0, 2'b01, tm(1, 5, 7),    1'b1, 1'b0);
        stream("h12", 4);

        // Channel 1 in 24 h mode next to channel 0 in 12 h mode
        set_w(0, tm(17, 45, 30), 1'b1, 2'b01, tm(17, 45, 30), 1'b0, 1'b0);
        set_w(1, tm(7, 0, 0),    1'b1, 2'b01, tm(7, 0, 0),    1'b0, 1'b0);
        set_w(2, tm(9, 15, 0),   1'b0, 2'b01, tm(9, 15, 0),   1'b0, 1'b0);
        set_w(3, tm(10, 0, 0),   1'b1, 2'b01, tm(10, 0, 0),   1'b0, 1'b0);
        stream("h24", 4);
        check("legal_err_cnt", err_cnt, 0);

        // Illegal words pass through unchanged
        set_w(0, tm(24, 0, 0),           1'b0, 2'b01, tm(24, 0, 0),           1'b0, 1'b1);
        set_w(1, raw(0, 9, 6, 0, 0, 0),  1'b1, 2'b01, raw(0, 9, 6, 0, 0, 0),  1'b0, 1'b1);
        set_w(2, raw(0, 10, 0, 0, 0, 0), 1'b0, 2'b01, raw(0, 10, 0, 0, 0, 0), 1'b0, 1'b1);
        stream("ill", 3);
        check("ill_err_cnt", err_cnt, 3);

        // Saturation of the error counter
        flood(100);
        check("cnt_103", err_cnt, 103);
        flood(200);
        check("cnt_sat", err_cnt, 255);

        // Mode change on the accepting edge; in-flight word keeps its mode
        set_w(0, tm(15, 0, 0), 1'b0, 2'b00, tm(15, 0, 0), 1'b0, 1'b0);
        set_w(1, tm(15, 0, 0), 1'b0, 2'b01, tm(3, 0, 0),  1'b1, 1'b0);
        set_w(2, tm(15, 0, 0), 1'b0, 2'b00, tm(15, 0, 0), 1'b0, 1'b0);
        stream("mode", 3);

        // Back-pressure: out_ready low for the first 5 cycles of a 4-word burst
        set_w(0, tm(14, 0, 0),  1'b0, 2'b01, tm(2, 0, 0),  1'b1, 1'b0);
        set_w(1, tm(3, 30, 0),  1'b0, 2'b01, tm(3, 30, 0), 1'b0, 1'b0);
        set_w(2, tm(21, 10, 10), 1'b0, 2'b01, tm(9, 10, 10), 1'b1, 1'b0);
        set_w(3, tm(12, 0, 1),  1'b0, 2'b01, tm(12, 0, 1), 1'b1, 1'b0);
        mode12_24 = 2'b01;
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 30 && rcv < 4; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 5);
            in_valid  = (sent < 4);
            in_ch     = 1'b0;
            in_time   = (sent < 4) ? sw[sent] : '0;
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                check("bp_in_ready_low", in_ready, 0);
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_time", out_time, exp_fix(se[0], 1'b0));
                check("bp_hold_pm", out_pm, sp[0]);
            end
            if (c == 4) check("bp_accepts", sent, 2);
            if (out_valid && out_ready) begin
                check("bp_time", out_time, exp_fix(se[rcv], 1'b0));
                check("bp_pm", out_pm, sp[rcv]);
                check("bp_err", out_err, 0);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        check("bp_received", rcv, 4);
        @(posedge clk);
        @(negedge clk);
        check("bp_no_dup", out_valid, 0);

        // Reset while both stages are full
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_time  = tm(22, 0, 0);
        @(posedge clk); #1;
        in_time  = tm(5, 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("full_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst2_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst2_valid", out_valid, 0);
        check("rst2_err_cnt", err_cnt, 0);
        check("rst2_time", out_time, 0);
        check("rst2_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst2_flushed", out_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
